// File: rtl/stk_eng_cmd.sv
// Per-engine stack command initiator: issues one push/pop to the pipe, waits for the
// write-back response (or a timeout), returns it to the client and tracks a shadow depth.
package stk_pkg;
  typedef enum logic [1:0] {
    OP_NOP  = 2'd0,
    OP_PUSH = 2'd1,
    OP_POP  = 2'd2
  } opcode_t;
endpackage

module stk_eng_cmd
  import stk_pkg::*;
#(
  parameter int TIMEOUT_W = 10,
  parameter int DEPTH_W   = 8
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               i_req_vld,
  input  opcode_t            i_req_opcode,
  input  logic [127:0]       i_req_dat,
  output logic               o_req_rdy,
  output opcode_t            o_cmd_opcode,
  output logic [127:0]       o_cmd_dat,
  input  logic               i_cmd_ack,
  input  logic               i_pipe_rsp_vld,
  input  logic [127:0]       i_pipe_rsp_dat,
  input  logic               i_pipe_rsp_err,
  output logic               o_rsp_vld,
  output logic [127:0]       o_rsp_dat,
  output logic               o_rsp_err,
  input  logic               i_rsp_rdy,
  output logic [DEPTH_W-1:0] o_depth,
  output logic               o_timeout,
  output logic               o_proto_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_WAIT = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  opcode_t              cmd_opcode_q, cmd_opcode_d;
  opcode_t              pend_op_q, pend_op_d;
  logic [127:0]         cmd_dat_q, cmd_dat_d;
  logic [127:0]         rsp_dat_q, rsp_dat_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 timeout_q, timeout_d;
  logic                 proto_err_q, proto_err_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [TIMEOUT_W-1:0] tmo_cnt_inc;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= S_IDLE;
      cmd_opcode_q <= OP_NOP;
      pend_op_q    <= OP_NOP;
      cmd_dat_q    <= '0;
      rsp_dat_q    <= '0;
      rsp_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
      proto_err_q  <= 1'b0;
      depth_q      <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      cmd_opcode_q <= cmd_opcode_d;
      pend_op_q    <= pend_op_d;
      cmd_dat_q    <= cmd_dat_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_err_q    <= rsp_err_d;
      timeout_q    <= timeout_d;
      proto_err_q  <= proto_err_d;
      depth_q      <= depth_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_opcode_d = cmd_opcode_q;
    pend_op_d    = pend_op_q;
    cmd_dat_d    = cmd_dat_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_err_d    = rsp_err_q;
    timeout_d    = timeout_q;
    proto_err_d  = proto_err_q;
    depth_d      = depth_q;
    tmo_cnt_d    = tmo_cnt_q;
    tmo_cnt_inc  = tmo_cnt_q + TIMEOUT_W'(1);

    // Stray handshakes never move data or depth, they only raise the sticky flag
    if (i_pipe_rsp_vld && (state_q != S_WAIT)) proto_err_d = 1'b1;
    if (i_cmd_ack && (state_q != S_CMD))       proto_err_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (i_req_vld) begin
          case (i_req_opcode)
            OP_PUSH, OP_POP: begin
              cmd_opcode_d = i_req_opcode;
              cmd_dat_d    = i_req_dat;
              pend_op_d    = i_req_opcode;
              state_d      = S_CMD;
            end
            default: begin
              rsp_dat_d = '0;
              rsp_err_d = 1'b0;
              state_d   = S_RSP;
            end
          endcase
        end
      end
      S_CMD: begin
        if (i_cmd_ack) begin
          cmd_opcode_d = OP_NOP;
          cmd_dat_d    = '0;
          tmo_cnt_d    = '0;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_pipe_rsp_vld) begin
          rsp_dat_d = i_pipe_rsp_dat;
          rsp_err_d = i_pipe_rsp_err;
          state_d   = S_RSP;
          if (!i_pipe_rsp_err) begin
            if ((pend_op_q == OP_PUSH) && !(&depth_q))
              depth_d = depth_q + DEPTH_W'(1);
            else if ((pend_op_q == OP_POP) && (depth_q != '0))
              depth_d = depth_q - DEPTH_W'(1);
          end
        end else if (&tmo_cnt_inc) begin
          // Counter reaching all-ones ends the wait with a forced zero/error response
          rsp_dat_d = '0;
          rsp_err_d = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_RSP;
        end else begin
          tmo_cnt_d = tmo_cnt_inc;
        end
      end
      S_RSP: begin
        if (i_rsp_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_req_rdy    = (state_q == S_IDLE);
  assign o_cmd_opcode = cmd_opcode_q;
  assign o_cmd_dat    = cmd_dat_q;
  assign o_rsp_vld    = (state_q == S_RSP);
  assign o_rsp_dat    = rsp_dat_q;
  assign o_rsp_err    = rsp_err_q;
  assign o_depth      = depth_q;
  assign o_timeout    = timeout_q;
  assign o_proto_err  = proto_err_q;

endmodule
